// File: rtl/mmc_block_writer.sv
// Writes block_count 512-byte pattern blocks to an MMC/SD card through the KFMMC_Drive register port.
// Pattern byte = low byte of block address + byte index; start/done/error host handshake.
module mmc_block_writer #(
  parameter int unsigned BLOCK_BYTES   = 512,
  parameter logic [7:0]  WRITE_COMMAND = 8'h81,
  parameter logic [31:0] TIMEOUT       = 32'h000FFFF0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] start_block,
  input  logic [7:0]  block_count,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  blocks_written,
  output logic [7:0]  internal_data_bus,
  output logic        write_block_address_1,
  output logic        write_block_address_2,
  output logic        write_block_address_3,
  output logic        write_block_address_4,
  output logic        write_access_command,
  output logic        write_data,
  input  logic        drive_busy,
  input  logic        request_write_data_interrupt,
  input  logic        write_completion_interrupt,
  input  logic        write_interface_error
);

  localparam int unsigned IDX_W = 10;
  localparam int unsigned TMR_W = 32;

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_READY, S_ADDR_1, S_ADDR_2, S_ADDR_3, S_ADDR_4, S_COMMAND,
    S_WAIT_REQUEST, S_SEND_BYTE, S_SEND_GAP, S_NEXT_BLOCK, S_FINISH
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        cur_block_q, cur_block_d;
  logic [7:0]         remaining_q, remaining_d;
  logic [IDX_W-1:0]   byte_index_q, byte_index_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               error_q, error_d;
  logic [7:0]         blocks_written_q, blocks_written_d;
  logic               waiting;

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [7:0]         bus_q, bus_d;
  logic [3:0]         addr_stb_q, addr_stb_d;
  logic               cmd_q, cmd_d;
  logic               wdata_q, wdata_d;

  // State, datapath and registered output flops; everything moves on the falling edge
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      cur_block_q      <= '0;
      remaining_q      <= '0;
      byte_index_q     <= '0;
      timer_q          <= '0;
      error_q          <= 1'b0;
      blocks_written_q <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      bus_q            <= '0;
      addr_stb_q       <= '0;
      cmd_q            <= 1'b0;
      wdata_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      cur_block_q      <= cur_block_d;
      remaining_q      <= remaining_d;
      byte_index_q     <= byte_index_d;
      timer_q          <= timer_d;
      error_q          <= error_d;
      blocks_written_q <= blocks_written_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      bus_q            <= bus_d;
      addr_stb_q       <= addr_stb_d;
      cmd_q            <= cmd_d;
      wdata_q          <= wdata_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d          = state_q;
    cur_block_d      = cur_block_q;
    remaining_d      = remaining_q;
    byte_index_d     = byte_index_q;
    error_d          = error_q;
    blocks_written_d = blocks_written_q;
    waiting          = (state_q == S_WAIT_READY) || (state_q == S_WAIT_REQUEST);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_block_d      = start_block;
          remaining_d      = block_count;
          error_d          = 1'b0;
          blocks_written_d = '0;
          byte_index_d     = '0;
          state_d          = (block_count == 8'd0) ? S_FINISH : S_WAIT_READY;
        end
      end
      S_WAIT_READY:   if (!drive_busy) state_d = S_ADDR_1;
      S_ADDR_1:       state_d = S_ADDR_2;
      S_ADDR_2:       state_d = S_ADDR_3;
      S_ADDR_3:       state_d = S_ADDR_4;
      S_ADDR_4:       state_d = S_COMMAND;
      S_COMMAND:      state_d = S_WAIT_REQUEST;
      S_WAIT_REQUEST: begin
        // Completion beats a simultaneous request; a wrong byte count is a short block or overrun
        if (write_completion_interrupt) begin
          if (byte_index_q == IDX_W'(BLOCK_BYTES)) begin
            state_d = S_NEXT_BLOCK;
          end else begin
            error_d = 1'b1;
            state_d = S_FINISH;
          end
        end else if (request_write_data_interrupt) begin
          if (byte_index_q < IDX_W'(BLOCK_BYTES)) begin
            state_d = S_SEND_BYTE;
          end else begin
            error_d = 1'b1;
            state_d = S_FINISH;
          end
        end
      end
      S_SEND_BYTE: begin
        byte_index_d = byte_index_q + IDX_W'(1);
        state_d      = S_SEND_GAP;
      end
      S_SEND_GAP:     state_d = S_WAIT_REQUEST;
      S_NEXT_BLOCK: begin
        blocks_written_d = blocks_written_q + 8'd1;
        cur_block_d      = cur_block_q + 32'd1;
        remaining_d      = remaining_q - 8'd1;
        byte_index_d     = '0;
        state_d          = (remaining_q == 8'd1) ? S_FINISH : S_WAIT_READY;
      end
      S_FINISH:       state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase

    if (waiting && (state_d == state_q) && ((timer_q + TMR_W'(1)) >= TIMEOUT)) begin
      error_d = 1'b1;
      state_d = S_FINISH;
    end

    if ((state_q != S_IDLE) && (state_q != S_FINISH) && write_interface_error) begin
      error_d = 1'b1;
      state_d = S_FINISH;
    end

    timer_d = (waiting && (state_d == state_q)) ? timer_q + TMR_W'(1) : '0;
  end

  // Output decode of the current state, registered one cycle later
  always_comb begin
    busy_d     = (state_q != S_IDLE);
    done_d     = (state_q == S_FINISH);
    bus_d      = 8'h00;
    addr_stb_d = 4'b0000;
    cmd_d      = 1'b0;
    wdata_d    = 1'b0;
    unique case (state_q)
      S_ADDR_1:    begin addr_stb_d = 4'b0001; bus_d = cur_block_q[7:0];   end
      S_ADDR_2:    begin addr_stb_d = 4'b0010; bus_d = cur_block_q[15:8];  end
      S_ADDR_3:    begin addr_stb_d = 4'b0100; bus_d = cur_block_q[23:16]; end
      S_ADDR_4:    begin addr_stb_d = 4'b1000; bus_d = cur_block_q[31:24]; end
      S_COMMAND:   begin cmd_d = 1'b1; bus_d = WRITE_COMMAND; end
      S_SEND_BYTE: begin wdata_d = 1'b1; bus_d = cur_block_q[7:0] + byte_index_q[7:0]; end
      default:     bus_d = 8'h00;
    endcase
  end

  assign busy                  = busy_q;
  assign done                  = done_q;
  assign error                 = error_q;
  assign blocks_written        = blocks_written_q;
  assign internal_data_bus     = bus_q;
  assign write_block_address_1 = addr_stb_q[0];
  assign write_block_address_2 = addr_stb_q[1];
  assign write_block_address_3 = addr_stb_q[2];
  assign write_block_address_4 = addr_stb_q[3];
  assign write_access_command  = cmd_q;
  assign write_data            = wdata_q;

endmodule

// File: doc/mmc_block_writer.md
# mmc_block_writer

Sequencer that writes one or more 512-byte blocks of a deterministic test pattern to an MMC/SD card through the `KFMMC_Drive` byte-wide register interface. It is the write-direction counterpart of the block-read test harness. It issues the block address and write command, answers each write-data request with one pattern byte, and waits for write completion. It then advances to the next block or reports done or error to a host-side start/done handshake.

## Interface
Parameters:
- `BLOCK_BYTES`, default 512: bytes per block. The byte index counter is 10 bits wide.
- `WRITE_COMMAND`, default 8'h81: access-command byte for a single-block write.
- `TIMEOUT`, default 32'h000FFFF0: clock cycles allowed in any wait state before the block flags an error.

Ports:
- `clock`  in  1  system clock; all flops update on the falling edge
- `reset`  in  1  reset, asynchronous, active-high
- `start`  in  1  one-cycle request; sampled only in IDLE
- `start_block`  in  32  first block address, latched on start
- `block_count`  in  8  number of blocks to write, latched on start
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when the sequence ends, on both success and error
- `error`  out  1  sticky; cleared on the next accepted start
- `blocks_written`  out  8  count of blocks that completed successfully
- `internal_data_bus`  out  8  byte to the drive; 8'h00 when no strobe is active
- `write_block_address_1..4`  out  1 each  address byte strobes (byte 1 = [7:0] … byte 4 = [31:24])
- `write_access_command`  out  1  command strobe
- `write_data`  out  1  data byte strobe
- `drive_busy`  in  1  drive busy
- `request_write_data_interrupt`  in  1  drive wants the next byte (level)
- `write_completion_interrupt`  in  1  block write finished
- `write_interface_error`  in  1  drive-side failure

## Operation
States: IDLE, WAIT_READY, ADDR_1, ADDR_2, ADDR_3, ADDR_4, COMMAND, WAIT_REQUEST, SEND_BYTE, SEND_GAP, NEXT_BLOCK, FINISH.
- IDLE + start:
  - Latch `start_block` into `cur_block` and `block_count` into `remaining`.
  - Clear `error`, `blocks_written` and `byte_index`.
  - If `block_count` == 0, go to FINISH. Otherwise go to WAIT_READY.
- WAIT_READY: go to ADDR_1 when `drive_busy` is low.
- ADDR_1..ADDR_4: each state lasts one cycle, drives the matching `cur_block` byte on `internal_data_bus` and asserts the matching strobe.
- COMMAND: drive `WRITE_COMMAND` and assert `write_access_command` for one cycle, then go to WAIT_REQUEST.
- WAIT_REQUEST:
  - `write_completion_interrupt` has priority over the request. If `byte_index` == `BLOCK_BYTES`, go to NEXT_BLOCK. Otherwise set `error` and go to FINISH (short block).
  - Else, on `request_write_data_interrupt`: if `byte_index` < `BLOCK_BYTES`, go to SEND_BYTE. Otherwise set `error` and go to FINISH (overrun).
- SEND_BYTE: drive `internal_data_bus` = `cur_block[7:0] + byte_index[7:0]` (mod 256) and assert `write_data` for one cycle. Increment `byte_index`, then go to SEND_GAP.
- SEND_GAP: one idle cycle so the drive can deassert the request, then go to WAIT_REQUEST.
- NEXT_BLOCK:
  - Increment `blocks_written` and `cur_block` (32-bit wrap, FFFFFFFF → 0).
  - Decrement `remaining` and clear `byte_index`.
  - If `remaining` was 1, go to FINISH. Otherwise go to WAIT_READY.
- FINISH: pulse `done` for one cycle, then go to IDLE.
- `write_interface_error` in any state other than IDLE or FINISH: set `error` and go to FINISH.
- Timeout:
  - The counter clears on every state change and counts only in WAIT_READY and WAIT_REQUEST.
  - When it reaches `TIMEOUT`, set `error` and go to FINISH.
- A `start` pulse while busy is ignored.

## Timing
- Reset (async) forces IDLE and all outputs to 0, including `error` and `blocks_written`. Reset mid-block abandons the transfer with no done pulse.
- All strobes are registered state decodes and last exactly one cycle.
- From start to ADDR_1 takes at least 2 cycles with `drive_busy` low. The address and command phase is 5 cycles.
- Each byte takes at least 3 cycles: WAIT_REQUEST, SEND_BYTE, SEND_GAP.
- `done` rises on the cycle after the terminal event (completion of the last block, or error) has been registered.
- `busy` falls in the same cycle that `done` falls.

## Test plan
- `start_block`=0x00000005, `block_count`=1, drive model requests 512 bytes:
  - Address strobes carry 05, 00, 00, 00; command strobe carries 0x81.
  - Bytes written are 05, 06, … FF, 00, … 04 (repeating), 512 in total.
  - `done` pulses, `error`=0, `blocks_written`=1.
- `start_block`=0x000000FF, `block_count`=3:
  - Three address phases for FF, 100 and 101.
  - `blocks_written`=3, `error`=0.
- `block_count`=0: no drive strobes; `done` pulses exactly 2 cycles after start; `busy` is high for exactly 1 cycle.
- Completion asserted after 100 bytes: `error`=1, `done` pulses, `blocks_written`=0.
- `write_interface_error` pulsed mid-block 2 of 3: `error`=1, `blocks_written`=1, and no further strobes.
- `drive_busy` held high with `TIMEOUT`=16: `error`=1 after 16 cycles in WAIT_READY. Separately, reset asserted mid-transfer: all outputs 0 immediately, and the next start works normally.
